// File: rtl/pm_capture_ctrl_if.sv
// Output stream between the post-mortem capture controller and the NPI write
// master. One word moves on every cycle where m_valid and m_ready are both 1.
//   m_valid : word valid (master)
//   m_ready : write master accepts word (slave)
//   m_data  : sample word (master)
//   m_addr  : ring address of the word (master)
//   m_last  : final word of the current burst (master)
interface pm_capture_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [31:0]       m_addr;
  logic              m_last;

  modport master (output m_valid, m_data, m_addr, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_addr, m_last, output m_ready);
endinterface

// File: rtl/pm_capture_ctrl.sv
// Post-mortem capture controller. Each trig seen while armed becomes an
// {ring_addr, sample_data} entry in an internal FIFO. The FIFO drains to the
// NPI write master as fixed-length bursts. A stop (rising npi_stop or falling
// npi_enable) flushes whatever is left as one shorter burst, latches the stop
// address and freezes until usr_rst.
//
// Ports:
//   clk, reset              : system clock, async active-low reset
//   trig, ring_addr,
//   sample_data             : sample strobe with its address and data word
//   npi_enable, npi_stop    : capture enable / stop from the timing generator
//   usr_rst                 : user re-arm / abort pulse
//   stream                  : valid/ready output words (master side)
//   pm_frozen, pm_stop_addr : freeze flag and ring address latched at stop
//   overflow, drop_cnt      : sticky drop flag, saturating drop counter
//   state_out               : current FSM state
//
// state  | meaning
// IDLE   | waiting for npi_enable
// ARMED  | capturing samples, emitting full bursts
// FLUSH  | capture stopped, draining remaining words
// FROZEN | buffer stable, waiting for usr_rst
module pm_capture_ctrl #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic                npi_enable,
  input  logic                npi_stop,
  input  logic [31:0]         ring_addr,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic                usr_rst,
  pm_capture_ctrl_if.master   stream,
  output logic                pm_frozen,
  output logic [31:0]         pm_stop_addr,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic [1:0]          state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(BURST_LEN);
  localparam int EW = DATA_W + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FLUSH  = 2'd2,
    FROZEN = 2'd3
  } state_t;

  state_t            state;
  logic              stop_q;
  logic              en_q;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       addr_q;
  logic [RW-1:0]     rem;

  logic          xfer;
  logic [CW-1:0] avail;
  logic          start_ok;
  logic          start;
  logic          advance;
  logic          load;
  logic          arm_trig;
  logic          full;
  logic          push;
  logic          drop;
  logic [CW-1:0] burst_len;
  logic [EW-1:0] head;
  logic          leave_armed;

  // The presented word stays counted in the FIFO until it is accepted, so
  // the output register never adds capacity beyond FIFO_DEPTH. The next word
  // is read one slot past rd_ptr when the current one is leaving this cycle.
  assign xfer        = valid_q & stream.m_ready;
  assign avail       = count - CW'(xfer);
  assign start_ok    = ((state == ARMED) && (avail >= CW'(BURST_LEN))) ||
                       ((state == FLUSH) && (avail != '0));
  assign start       = !usr_rst && (!valid_q || (xfer && last_q)) && start_ok;
  assign advance     = !usr_rst && xfer && !last_q;
  assign load        = start || advance;
  assign arm_trig    = (state == ARMED) && trig && !usr_rst;
  assign full        = (count == CW'(FIFO_DEPTH));
  assign push        = arm_trig && (!full || xfer);
  assign drop        = arm_trig && full && !xfer;
  assign burst_len   = (avail >= CW'(BURST_LEN)) ? CW'(BURST_LEN) : avail;
  assign head        = mem[rd_ptr + AW'(xfer)];
  assign leave_armed = (state == ARMED) &&
                       ((npi_stop && !stop_q) || (en_q && !npi_enable));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ring_addr, sample_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      rem      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (usr_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      rem      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (xfer) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(xfer);
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= head[DATA_W-1:0];
        addr_q  <= head[EW-1:DATA_W];
        // rem counts words of this burst still behind the presented one
        if (start) begin
          rem    <= RW'(burst_len - CW'(1));
          last_q <= (burst_len == CW'(1));
        end else begin
          rem    <= rem - RW'(1);
          last_q <= (rem == RW'(1));
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      stop_q       <= 1'b0;
      en_q         <= 1'b0;
      pm_stop_addr <= '0;
    end else begin
      stop_q <= npi_stop;
      en_q   <= npi_enable;
      if (usr_rst) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:   if (npi_enable) state <= ARMED;
          ARMED:  if (leave_armed) begin
                    state        <= FLUSH;
                    pm_stop_addr <= ring_addr;
                  end
          FLUSH:  if ((count == '0) && !valid_q) state <= FROZEN;
          FROZEN: state <= FROZEN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stream.m_valid = valid_q;
  assign stream.m_data  = data_q;
  assign stream.m_addr  = addr_q;
  assign stream.m_last  = last_q;
  assign pm_frozen      = (state == FROZEN);
  assign state_out      = state;

endmodule

// File: doc/pm_capture_ctrl.md
Name: pm_capture_ctrl

Overview:
- Downstream consumer of the post-mortem timing generator: takes the FA sample strobe, NPI enable/stop and ring address count, and turns each enabled sample into an addressed word for the NPI write master.
- Buffers samples in an internal FIFO and emits them as fixed-length bursts over a valid/ready stream.
- On stop, flushes the partial burst, latches the stop address, and freezes until user reset so software can read the post-mortem ring.

Parameters:
- DATA_W, 32, sample data width.
- BURST_LEN, 16, words per NPI burst (power of 2, >=2).
- FIFO_DEPTH, 32, internal FIFO entries (power of 2, >= 2*BURST_LEN).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- trig  in  1  FA sample strobe, one-cycle pulse.
- npi_enable  in  1  capture enable from timing generator.
- npi_stop  in  1  stop pulse from timing generator (one or more cycles high).
- ring_addr  in  32  ring address count, valid with trig.
- sample_data  in  DATA_W  sample word, valid with trig.
- usr_rst  in  1  user re-arm pulse.
- m_valid  out  1  output word valid.
- m_ready  in  1  write master accepts word.
- m_data  out  DATA_W  output word.
- m_addr  out  32  ring address of output word.
- m_last  out  1  last word of current burst.
- pm_frozen  out  1  capture stopped, buffer stable.
- pm_stop_addr  out  32  ring_addr latched at stop.
- overflow  out  1  sticky: a sample was dropped.
- drop_cnt  out  16  dropped-sample count, saturating.
- state_out  out  2  current FSM state.

Behaviour:
- Reset (reset=0): state IDLE; FIFO empty; m_valid=0, m_last=0, m_data=0, m_addr=0; pm_frozen=0; pm_stop_addr=0; overflow=0; drop_cnt=0.
- FSM states and encodings: IDLE=0, ARMED=1, FLUSH=2, FROZEN=3.
  - IDLE -> ARMED when npi_enable=1.
  - ARMED -> FLUSH on the rising edge of npi_stop, or when npi_enable falls (1->0), whichever comes first.
  - FLUSH -> FROZEN when the FIFO is empty and no burst is in progress.
  - FROZEN -> IDLE on usr_rst.
  - usr_rst in ARMED or FLUSH: abort, clear FIFO, deassert m_valid, go IDLE.
  - usr_rst in any state clears overflow and drop_cnt.
- Capture:
  - In ARMED, each trig=1 cycle pushes {ring_addr, sample_data}; the push is written at the next edge.
  - trig is ignored outside ARMED, and on the cycle of the ARMED->FLUSH transition the sample is pushed.
  - Transition and stop latch: pm_stop_addr <= ring_addr at that edge.
- Overflow:
  - trig while the FIFO is full drops the sample; overflow <= 1 (sticky); drop_cnt increments and saturates at 16'hFFFF.
  - A simultaneous pop frees space: push succeeds when push and pop coincide at full.
- Burst output:
  - Burst starts when not in a burst and (FIFO count >= BURST_LEN, or state is FLUSH and count > 0).
  - Burst length is BURST_LEN, or in FLUSH the count at burst start (min 1).
  - m_valid holds with stable m_data/m_addr until m_ready=1; a word transfers on m_valid & m_ready.
  - m_last=1 on the final word of each burst. Back-to-back bursts are allowed with no idle cycle.
  - Output is registered, first-word valid latency 1 cycle after the start condition.
  - A burst in progress always completes, including across the ARMED->FLUSH transition; no burst is abandoned except by reset/usr_rst.
- pm_frozen = (state == FROZEN).
- Widths: FIFO count is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- state_out reflects the registered state.

Test Plan:
- Basic burst: npi_enable=1, 16 trigs with ring_addr 0..15, data=addr*3, m_ready=1 -> one burst of 16 words, m_addr 0..15, m_last on addr 15, FIFO empty.
- Stop flush: 21 trigs then npi_stop -> burst of 16 then burst of 5 (m_last on 5th), pm_stop_addr=ring_addr at stop, pm_frozen=1 after last transfer, state_out=3.
- Backpressure: m_ready=0 for 40 trigs -> 32 stored, overflow=1, drop_cnt=8; release m_ready -> 32 words in order, addresses continuous.
- Ready toggling: m_ready alternating 1/0 during a burst -> m_data/m_addr stable while stalled, no duplicated or lost words.
- Abort: usr_rst mid-burst in ARMED -> m_valid=0 next cycle, state IDLE, overflow=0, drop_cnt=0, FIFO empty.
- Async reset: assert reset=0 mid-FLUSH -> all outputs at reset values immediately, with no clock edge required.
